sram_array_ctrl: RTL and testbench

- Digital-to-analog front end that sits directly upstream of cell_array.
- Accepts single-word read/write requests over a valid/ready handshake.
- Sequences the real-valued wordlines (row_wr, row_rd) and write bitlines (bl_wr, blb_wr) with fixed setup, pulse and recovery timing.
- Senses the read bitlines (bl_rd, blb_rd) against VTH and returns a registered digital word.

---
 rtl/sram_pkg.sv | 19 +
 rtl/sram_sense_amp.sv | 22 ++
 rtl/sram_array_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sram_array_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared analog levels, sense threshold and controller state encoding for the
// SRAM array front end.
package sram_pkg;

   localparam real VDD   = 1.5;
   localparam real VSS   = 0.0;
   localparam real VTH   = 0.8;
   localparam int  TMR_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WR_SETUP = 3'd1,
      ST_WR_PULSE = 3'd2,
      ST_RD_PULSE = 3'd3,
      ST_SAMPLE   = 3'd4,
      ST_RECOVER  = 3'd5
   } state_t;

endpackage

// File: rtl/sram_sense_amp.sv
// Single-column differential sense: resolves a bitline pair against VTH and
// flags pairs that are both high or both low.
module sram_sense_amp
   import sram_pkg::*;
(
   input  real  i_bl,
   input  real  i_blb,
   output logic o_bit,
   output logic o_amb
);

   logic w_bl_hi;
   logic w_blb_hi;

   always_comb begin
      w_bl_hi  = (i_bl >= VTH);
      w_blb_hi = (i_blb >= VTH);
      o_bit    = w_bl_hi && !w_blb_hi;
      o_amb    = (w_bl_hi == w_blb_hi);
   end

endmodule

// File: rtl/sram_array_ctrl.sv
// Request-driven sequencer for the cell array: drives real-valued wordlines and
// write bitlines with fixed setup/pulse/recovery timing and senses read data.
module sram_array_ctrl
   import sram_pkg::*;
#(
   parameter int ROWS     = 1,
   parameter int COLS     = 1,
   parameter int ADDR_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int WR_PULSE = 4,
   parameter int RD_PULSE = 4,
   parameter int RECOVER  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [COLS-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [COLS-1:0]   rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output real               row_wr [ROWS],
   output real               row_rd [ROWS],
   output real               bl_wr  [COLS],
   output real               blb_wr [COLS],
   input  real               bl_rd  [COLS],
   input  real               blb_rd [COLS]
);

   state_t             r_state;
   logic [TMR_W-1:0]   r_tmr;
   logic               r_ready;
   logic [ROWS-1:0]    r_sel;
   logic               r_addr_ok;
   logic [COLS-1:0]    r_wdata;
   logic [ROWS-1:0]    r_row_wr_en;
   logic [ROWS-1:0]    r_row_rd_en;
   logic               r_bl_en;
   logic               r_rsp_valid;
   logic [COLS-1:0]    r_rsp_rdata;
   logic               r_rsp_err;
   logic [ROWS-1:0]    w_req_sel;
   logic [COLS-1:0]    w_sense_bit;
   logic [COLS-1:0]    w_sense_amb;
   logic               w_accept;
   logic               w_tmr_done;

   // Out-of-range addresses decode to no row, which suppresses every wordline.
   always_comb begin
      w_req_sel = '0;
      for (int r = 0; r < ROWS; r++) begin
         w_req_sel[r] = (32'(req_addr) == r);
      end
   end

   assign w_accept   = req_valid && r_ready;
   assign w_tmr_done = (r_tmr == '0);

   for (genvar c = 0; c < COLS; c++) begin : g_sense
      sram_sense_amp u_sense_amp (
         .i_bl  (bl_rd[c]),
         .i_blb (blb_rd[c]),
         .o_bit (w_sense_bit[c]),
         .o_amb (w_sense_amb[c])
      );
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_sel     <= w_req_sel;
         r_addr_ok <= |w_req_sel;
         r_wdata   <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tmr       <= '0;
         r_ready     <= 1'b0;
         r_row_wr_en <= '0;
         r_row_rd_en <= '0;
         r_bl_en     <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_ready <= 1'b0;
                  if (req_we) begin
                     r_state <= ST_WR_SETUP;
                     r_bl_en <= 1'b1;
                  end else begin
                     r_state     <= ST_RD_PULSE;
                     r_tmr       <= TMR_W'(RD_PULSE - 1);
                     r_row_rd_en <= w_req_sel;
                  end
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_WR_SETUP: begin
               r_state     <= ST_WR_PULSE;
               r_tmr       <= TMR_W'(WR_PULSE - 1);
               r_row_wr_en <= r_sel;
            end
            ST_WR_PULSE: begin
               if (w_tmr_done) begin
                  r_state     <= ST_RECOVER;
                  r_tmr       <= TMR_W'(RECOVER - 1);
                  r_row_wr_en <= '0;
               end else begin
                  r_tmr <= r_tmr - 1'b1;
               end
            end
            ST_RD_PULSE: begin
               if (w_tmr_done) r_state <= ST_SAMPLE;
               else            r_tmr   <= r_tmr - 1'b1;
            end
            ST_SAMPLE: begin
               r_state     <= ST_RECOVER;
               r_tmr       <= TMR_W'(RECOVER - 1);
               r_row_rd_en <= '0;
               r_rsp_valid <= 1'b1;
               r_rsp_rdata <= r_addr_ok ? w_sense_bit : '0;
               r_rsp_err   <= !r_addr_ok || (|w_sense_amb);
            end
            ST_RECOVER: begin
               // Bitlines stay driven through the first recovery cycle so they
               // always fall after the write wordline.
               r_bl_en <= 1'b0;
               if (w_tmr_done) r_state <= ST_IDLE;
               else            r_tmr   <= r_tmr - 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      for (int r = 0; r < ROWS; r++) begin
         row_wr[r] = r_row_wr_en[r] ? VDD : VSS;
         row_rd[r] = r_row_rd_en[r] ? VDD : VSS;
      end
      for (int c = 0; c < COLS; c++) begin
         bl_wr[c]  = (r_bl_en &&  r_wdata[c]) ? VDD : VSS;
         blb_wr[c] = (r_bl_en && !r_wdata[c]) ? VDD : VSS;
      end
   end

   assign req_ready = r_ready;
   assign busy      = (r_state != ST_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench for sram_array_ctrl: drives requests and bitline levels and
// checks wordline/bitline sequencing, sensed data and handshake timing.
module tb_sram_array_ctrl;
   import sram_pkg::*;

   localparam int ROWS   = 3;
   localparam int COLS   = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [COLS-1:0]   req_wdata;
   logic              rsp_valid;
   logic [COLS-1:0]   rsp_rdata;
   logic              rsp_err;
   logic              busy;
   real               row_wr [ROWS];
   real               row_rd [ROWS];
   real               bl_wr  [COLS];
   real               blb_wr [COLS];
   real               bl_rd  [COLS];
   real               blb_rd [COLS];

   int n_chk = 0;
   int n_fail = 0;
   int excl_viol = 0;
   int mon_hi;

   int sum_wr_tgt, sum_wr_all, sum_rd_tgt, sum_rd_all;
   int first_pulse, rsp_cnt, rsp_step, rdy_step, bl_leak;
   logic [COLS-1:0] got_rdata;
   logic            got_err;
   real tr_bl0 [12];
   real tr_blb0[12];
   real tr_bl1 [12];

   sram_array_ctrl #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .ADDR_W   (ADDR_W),
      .WR_PULSE (4),
      .RD_PULSE (4),
      .RECOVER  (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .row_wr    (row_wr),
      .row_rd    (row_rd),
      .bl_wr     (bl_wr),
      .blb_wr    (blb_wr),
      .bl_rd     (bl_rd),
      .blb_rd    (blb_rd)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // At most one wordline of either kind may be at VDD in any cycle.
   always @(negedge clk) begin
      mon_hi = 0;
      for (int r = 0; r < ROWS; r++) begin
         if (row_wr[r] == VDD) mon_hi++;
         if (row_rd[r] == VDD) mon_hi++;
      end
      if (mon_hi > 1) excl_viol++;
   end

   task automatic check(input string tag, input real obs, input real exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: observed %g, expected %g", tag, obs, exp);
      end
   endtask

   task automatic set_bl(input logic [COLS-1:0] w);
      for (int c = 0; c < COLS; c++) begin
         bl_rd[c]  = w[c] ? VDD : VSS;
         blb_rd[c] = w[c] ? VSS : VDD;
      end
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("handshake ready", req_ready, 1);
   endtask

   // Step k is the negedge that follows the k-th edge after the acceptance edge.
   task automatic run_op(input logic we, input int addr, input logic [COLS-1:0] wd);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = ADDR_W'(addr);
      req_wdata = wd;
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      sum_wr_tgt = 0; sum_wr_all = 0; sum_rd_tgt = 0; sum_rd_all = 0;
      first_pulse = -1; rsp_cnt = 0; rsp_step = -1; rdy_step = -1; bl_leak = 0;
      got_rdata = '0; got_err = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         for (int r = 0; r < ROWS; r++) begin
            if (row_wr[r] == VDD) begin
               sum_wr_all++;
               if (r == addr) sum_wr_tgt++;
               if (first_pulse < 0) first_pulse = k;
            end
            if (row_rd[r] == VDD) begin
               sum_rd_all++;
               if (r == addr) sum_rd_tgt++;
               if (first_pulse < 0) first_pulse = k;
            end
         end
         for (int c = 0; c < COLS; c++) begin
            if (!we && (bl_wr[c] != VSS || blb_wr[c] != VSS)) bl_leak++;
         end
         tr_bl0[k]  = bl_wr[0];
         tr_blb0[k] = blb_wr[0];
         tr_bl1[k]  = bl_wr[1];
         if (rsp_valid) begin
            rsp_cnt++;
            rsp_step  = k;
            got_rdata = rsp_rdata;
            got_err   = rsp_err;
         end
         if (req_ready && rdy_step < 0) rdy_step = k;
      end
   endtask

   initial begin
      int last_wr;
      int first_rd;
      logic [COLS-1:0] b2b_rdata;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      set_bl('0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset req_ready", req_ready, 0);
      check("reset busy", busy, 0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_rdata", rsp_rdata, 0);
      check("reset rsp_err", rsp_err, 0);
      check("reset row_wr0", row_wr[0], VSS);
      check("reset bl_wr0", bl_wr[0], VSS);
      rst = 1'b0;
      @(negedge clk);
      check("ready after reset", req_ready, 1);

      // Write 4'b0101 to row 0.
      run_op(1'b1, 0, 4'b0101);
      check("wr pulse len", sum_wr_tgt, 4);
      check("wr all rows", sum_wr_all, 4);
      check("wr no read wl", sum_rd_all, 0);
      check("wr pulse start", first_pulse, 1);
      check("wr setup bl0", tr_bl0[0], VDD);
      check("wr setup blb0", tr_blb0[0], VSS);
      check("wr setup bl1", tr_bl1[0], VSS);
      check("wr bl0 in first recover", tr_bl0[5], VDD);
      check("wr bl0 released", tr_bl0[6], VSS);
      check("wr no rsp", rsp_cnt, 0);
      check("wr ready latency", rdy_step, 8);

      // Read row 0 back.
      set_bl(4'b0101);
      run_op(1'b0, 0, '0);
      check("rd wl len", sum_rd_tgt, 5);
      check("rd all rows", sum_rd_all, 5);
      check("rd no write wl", sum_wr_all, 0);
      check("rd wl start", first_pulse, 0);
      check("rd rsp count", rsp_cnt, 1);
      check("rd rsp step", rsp_step, 5);
      check("rd rdata 0101", got_rdata, 4'b0101);
      check("rd err 0101", got_err, 0);
      check("rd bitlines idle", bl_leak, 0);
      check("rd ready latency", rdy_step, 8);

      // Write 4'b1010 to row 2: column 0 drives the complementary line.
      run_op(1'b1, 2, 4'b1010);
      check("wr0 bl0 in pulse", tr_bl0[2], VSS);
      check("wr0 blb0 in pulse", tr_blb0[2], VDD);
      check("wr0 pulse len", sum_wr_tgt, 4);
      set_bl(4'b1010);
      run_op(1'b0, 2, '0);
      check("rd rdata 1010", got_rdata, 4'b1010);
      check("rd err 1010", got_err, 0);

      // Column 2 ambiguous (both lines above threshold).
      set_bl(4'b1111);
      bl_rd[2] = 1.0; blb_rd[2] = 1.0;
      run_op(1'b0, 1, '0);
      check("amb rdata", got_rdata, 4'b1011);
      check("amb err", got_err, 1);

      // Exactly VTH counts as high.
      set_bl(4'b0000);
      bl_rd[3] = VTH; blb_rd[3] = 0.79;
      run_op(1'b0, 1, '0);
      check("vth rdata", got_rdata, 4'b1000);
      check("vth err", got_err, 0);

      // Out-of-range read and write.
      set_bl(4'b1111);
      run_op(1'b0, 3, '0);
      check("oor rd wl", sum_rd_all, 0);
      check("oor rd rsp", rsp_cnt, 1);
      check("oor rd rdata", got_rdata, 0);
      check("oor rd err", got_err, 1);
      check("oor rd ready", rdy_step, 8);
      run_op(1'b1, 3, 4'b1111);
      check("oor wr wl", sum_wr_all, 0);
      check("oor wr rsp", rsp_cnt, 0);

      // Back-to-back: valid held high, write then read to row 1.
      set_bl(4'b0110);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd1; req_wdata = 4'b0110;
      wait_ready();
      @(posedge clk);
      #1;
      req_we = 1'b0;
      last_wr = -1; first_rd = -1; b2b_rdata = '0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (row_wr[1] == VDD) last_wr = k;
         if (row_rd[1] == VDD) begin
            if (first_rd < 0) first_rd = k;
            req_valid = 1'b0;
         end
         if (rsp_valid) b2b_rdata = rsp_rdata;
      end
      req_valid = 1'b0;
      check("b2b last write step", last_wr, 4);
      check("b2b idle gap", first_rd - last_wr - 1, 4);
      check("b2b rdata", b2b_rdata, 4'b0110);

      // Reset in the middle of a write pulse.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 4'b1111;
      wait_ready();
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre-reset wl high", row_wr[0], VDD);
      rst = 1'b1;
      @(negedge clk);
      check("midreset row_wr0", row_wr[0], VSS);
      check("midreset bl_wr0", bl_wr[0], VSS);
      check("midreset busy", busy, 0);
      check("midreset ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post-reset ready", req_ready, 1);
      check("post-reset rsp_valid", rsp_valid, 0);
      check("post-reset busy", busy, 0);

      check("wordline exclusion", excl_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
